hazard_unit: RTL and testbench
==============================

# hazard_unit

Stall/forward controller for the five-stage MIPS pipeline. Consumes the decoded D-stage register addresses and Tuse flags plus the E/M/W pipelined A1/A2/A3/res tags, and produces the stall, E-bubble and forwarding-mux selects. It also owns the multiply/divide busy counter that drives `stall_md` back into the E-stage tag register.

## Interface
- `MULT_CYCLES`, default 5: busy cycles after a mult/multu issues in E.
- `DIV_CYCLES`, default 10: busy cycles after a div/divu issues in E.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `A1_D`, `A2_D`  in  5  rs/rt of the D instruction.
- `Tuse_rs0`, `Tuse_rs1`  in  1  rs needed in D / in E (neither asserted means no rs use).
- `Tuse_rt0`, `Tuse_rt1`, `Tuse_rt2`  in  1  rt needed in D / E / M.
- `md_use_D`  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `A1_E`, `A2_E`, `A3_E`, `res_E`  in  5/5/5/3  E-stage tags.
- `A2_M`, `A3_M`, `res_M`  in  5/5/3  M-stage tags.
- `A3_W`, `res_W`  in  5/3  W-stage tags.
- `md_start_E`  in  1  mult/div in E this cycle.
- `md_div_E`  in  1  qualifies `md_start_E`: 1 = div, 0 = mult.
- `stall`  out  1  freeze PC and IF/ID.
- `clrE`  out  1  bubble into ID/EX on a data hazard.
- `stall_md`  out  1  bubble into ID/EX on an md-busy hazard.
- `fwd_rs_D`, `fwd_rt_D`  out  2  D-stage compare/jr operand select.
- `fwd_rs_E`, `fwd_rt_E`  out  2  ALU operand select.
- `fwd_rt_M`  out  1  store-data select (1 = W).
- `md_busy`  out  1  md unit busy.
- `stall_cycles`  out  16  saturating count of stalled cycles.

## Operation
- `res` codes: NW=0 (no write), ALU=1, DM=2, PC=3 (jal/jalr), MD=4 (mfhi/mflo).
- Tnew by res:
  - In E: ALU=1, MD=1, DM=2, PC=0.
  - In M: DM=1, all others 0.
  - In W: 0.
- Tuse: rs is 0 if `Tuse_rs0`, 1 if `Tuse_rs1`, else 3. rt is 0/1/2 from `Tuse_rt0`/`Tuse_rt1`/`Tuse_rt2`, else 3.
- Data stall: a stage X in {E, M} with `res_X` != NW, `A3_X` != 0, `A3_X` == `A1_D` (or `A2_D`) and Tuse < Tnew_X.
  - `clrE` = data stall.
- md hazard: `stall_md` = `md_use_D` & `md_busy` & !data stall. Data stall takes priority, so at most one of `clrE`/`stall_md` is asserted.
- `stall` = `clrE` | `stall_md`.
- Forward codes: 0 = register/pipe value, 1 = M, 2 = W, 3 = E (PC+8 only). A source matches on equal address, nonzero address, and res != NW.
  - D-stage operands: priority E (only if `res_E`==PC), then M (if `res_M` != DM), then W.
  - E-stage operands (`A1_E`/`A2_E`): priority M (if `res_M` != DM), then W.
  - M-stage store data (`A2_M`): W.
  - Register 0 never forwards.
- md counter `cnt`:
  - Loads `DIV_CYCLES` or `MULT_CYCLES` on `md_start_E`, reloading even if already busy.
  - Otherwise decrements when nonzero.
  - `md_busy` = `md_start_E` | (`cnt` != 0).
- `stall_cycles` increments on every cycle with `stall`=1 and holds at 0xFFFF.

## Timing
- All hazard and forward outputs are combinational from the current inputs, valid in the same cycle.
- For mult issued in E in cycle k: `md_busy`=1 in cycles k..k+5, 0 from k+6. For div: k..k+10.
- Reset: `cnt`=0 and `stall_cycles`=0 at the edge. During reset all outputs derive from the inputs, which the tag registers hold at zero, so every output is 0.
- Reset mid-multiply aborts the count: `md_busy`=0 in the cycle after reset.
- `md_start_E` while `cnt`=1 reloads; no gap in `md_busy`.

## Structure
- Package `hazard_pkg` holds the res codes, the forward-select codes, and the default `MULT_CYCLES`/`DIV_CYCLES`.
- Sub-module `md_busy_ctr`:
  - Contains the counter and busy logic.
  - Parameters `MULT_CYCLES`, `DIV_CYCLES`.
  - Ports `clk`, `reset`, `start`, `is_div`, `busy`.
- The remainder is the top-level comparator logic plus the stall counter.

## Test plan
- lw $3 in E (`res_E`=DM, `A3_E`=3), D=beq using $3 (`Tuse_rs0`, `A1_D`=3) -> `stall`=1, `clrE`=1. Next cycle, lw in M -> still stalled. Following cycle, lw in W -> `stall`=0, `fwd_rs_D`=2.
- jal in E (`res_E`=PC, `A3_E`=31), D=jr $31 -> `stall`=0, `fwd_rs_D`=3. With `A1_D`=0 -> `fwd_rs_D`=0.
- addu $5 in M and lw $5 in W, E operand `A2_E`=5 -> `fwd_rt_E`=1. Same with `res_M`=NW -> `fwd_rt_E`=2.
- mult start (`md_div_E`=0), then `md_use_D`=1 held -> `stall_md`=1 for 6 cycles, `stall_cycles`=6. Div variant -> 11 cycles.
- Div start, reset asserted 3 cycles later -> `md_busy`=0 and `stall_cycles`=0 on the next cycle.
- Force `stall` for 70000 cycles -> `stall_cycles` saturates at 0xFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// ==========================================================================
// hazard_pkg : result codes, forward selects and Tnew helpers for hazard_unit
// Rev 1.0
// ==========================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [2:0] {
    RES_NW  = 3'd0,
    RES_ALU = 3'd1,
    RES_DM  = 3'd2,
    RES_PC  = 3'd3,
    RES_MD  = 3'd4
  } res_e;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_M   = 2'd1;
  localparam logic [1:0] FWD_W   = 2'd2;
  localparam logic [1:0] FWD_E   = 2'd3;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Cycles until the producer's result exists, measured from the E stage
  function automatic logic [1:0] tnew_e(input logic [2:0] res);
    case (res)
      RES_ALU, RES_MD: tnew_e = 2'd1;
      RES_DM:          tnew_e = 2'd2;
      default:         tnew_e = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tnew_m(input logic [2:0] res);
    tnew_m = (res == RES_DM) ? 2'd1 : 2'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_unit_if.sv
// ==========================================================================
// hazard_unit_if : pipeline tags in, stall/forward controls out
// Rev 1.0
// ==========================================================================
`default_nettype none

interface hazard_unit_if;
  logic [4:0] A1_D, A2_D;
  logic       Tuse_rs0, Tuse_rs1;
  logic       Tuse_rt0, Tuse_rt1, Tuse_rt2;
  logic       md_use_D;
  logic [4:0] A1_E, A2_E, A3_E;
  logic [2:0] res_E;
  logic [4:0] A2_M, A3_M;
  logic [2:0] res_M;
  logic [4:0] A3_W;
  logic [2:0] res_W;
  logic       md_start_E, md_div_E;
  logic       stall, clrE, stall_md;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic       fwd_rt_M;
  logic       md_busy;
  logic [15:0] stall_cycles;

  modport master (
    output A1_D, A2_D, Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2, md_use_D,
           A1_E, A2_E, A3_E, res_E, A2_M, A3_M, res_M, A3_W, res_W,
           md_start_E, md_div_E,
    input  stall, clrE, stall_md, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E,
           fwd_rt_M, md_busy, stall_cycles
  );

  modport slave (
    input  A1_D, A2_D, Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2, md_use_D,
           A1_E, A2_E, A3_E, res_E, A2_M, A3_M, res_M, A3_W, res_W,
           md_start_E, md_div_E,
    output stall, clrE, stall_md, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E,
           fwd_rt_M, md_busy, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/md_busy_ctr.sv
// ==========================================================================
// md_busy_ctr : multiply/divide busy countdown, reloaded on every start
// Rev 1.0
// ==========================================================================
`default_nettype none

module md_busy_ctr #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int C_MAX   = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CNT_W = $clog2(C_MAX + 1);

  logic [C_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (start)
      r_cnt <= is_div ? C_CNT_W'(DIV_CYCLES) : C_CNT_W'(MULT_CYCLES);
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  // Start counts as busy immediately so an md instruction right behind it waits
  assign busy = start | (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ==========================================================================
// hazard_unit : stall / forward controller for the five-stage MIPS pipeline
// Rev 1.0
// ==========================================================================
`default_nettype none

module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input logic           clk,
  input logic           reset,
  hazard_unit_if.slave  hz
);

  logic [1:0] w_tuse_rs, w_tuse_rt, w_tnew_E, w_tnew_M;
  logic       w_stall_E, w_stall_M, w_data_stall, w_stall_md, w_stall, w_md_busy;
  logic [15:0] r_stall_cycles;

  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst,
                               input logic [2:0] res);
    hit = (src == dst) && (dst != 5'd0) && (res != RES_NW);
  endfunction

  function automatic logic [1:0] sel_d(input logic [4:0] a,
                                       input logic [4:0] a3e, input logic [2:0] rese,
                                       input logic [4:0] a3m, input logic [2:0] resm,
                                       input logic [4:0] a3w, input logic [2:0] resw);
    if (hit(a, a3e, rese) && rese == RES_PC)      sel_d = FWD_E;
    else if (hit(a, a3m, resm) && resm != RES_DM) sel_d = FWD_M;
    else if (hit(a, a3w, resw))                   sel_d = FWD_W;
    else                                          sel_d = FWD_REG;
  endfunction

  function automatic logic [1:0] sel_e(input logic [4:0] a,
                                       input logic [4:0] a3m, input logic [2:0] resm,
                                       input logic [4:0] a3w, input logic [2:0] resw);
    if (hit(a, a3m, resm) && resm != RES_DM) sel_e = FWD_M;
    else if (hit(a, a3w, resw))              sel_e = FWD_W;
    else                                     sel_e = FWD_REG;
  endfunction

  // An unused operand gets Tuse=3, which no producer's Tnew can exceed
  assign w_tuse_rs = hz.Tuse_rs0 ? 2'd0 : hz.Tuse_rs1 ? 2'd1 : 2'd3;
  assign w_tuse_rt = hz.Tuse_rt0 ? 2'd0 : hz.Tuse_rt1 ? 2'd1 :
                     hz.Tuse_rt2 ? 2'd2 : 2'd3;
  assign w_tnew_E  = tnew_e(hz.res_E);
  assign w_tnew_M  = tnew_m(hz.res_M);

  assign w_stall_E = (hit(hz.A1_D, hz.A3_E, hz.res_E) && (w_tuse_rs < w_tnew_E)) ||
                     (hit(hz.A2_D, hz.A3_E, hz.res_E) && (w_tuse_rt < w_tnew_E));
  assign w_stall_M = (hit(hz.A1_D, hz.A3_M, hz.res_M) && (w_tuse_rs < w_tnew_M)) ||
                     (hit(hz.A2_D, hz.A3_M, hz.res_M) && (w_tuse_rt < w_tnew_M));
  assign w_data_stall = w_stall_E | w_stall_M;
  assign w_stall_md   = hz.md_use_D & w_md_busy & ~w_data_stall;
  assign w_stall      = w_data_stall | w_stall_md;

  md_busy_ctr #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_ctr (
    .clk    (clk),
    .reset  (reset),
    .start  (hz.md_start_E),
    .is_div (hz.md_div_E),
    .busy   (w_md_busy)
  );

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cycles <= '0;
    else if (w_stall && r_stall_cycles != 16'hFFFF)
      r_stall_cycles <= r_stall_cycles + 16'd1;
  end

  assign hz.stall        = w_stall;
  assign hz.clrE         = w_data_stall;
  assign hz.stall_md     = w_stall_md;
  assign hz.md_busy      = w_md_busy;
  assign hz.stall_cycles = r_stall_cycles;
  assign hz.fwd_rs_D = sel_d(hz.A1_D, hz.A3_E, hz.res_E, hz.A3_M, hz.res_M, hz.A3_W, hz.res_W);
  assign hz.fwd_rt_D = sel_d(hz.A2_D, hz.A3_E, hz.res_E, hz.A3_M, hz.res_M, hz.A3_W, hz.res_W);
  assign hz.fwd_rs_E = sel_e(hz.A1_E, hz.A3_M, hz.res_M, hz.A3_W, hz.res_W);
  assign hz.fwd_rt_E = sel_e(hz.A2_E, hz.A3_M, hz.res_M, hz.A3_W, hz.res_W);
  assign hz.fwd_rt_M = hit(hz.A2_M, hz.A3_W, hz.res_W);

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ==========================================================================
// tb_hazard_unit : scoreboard bench for hazard_unit
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_hazard_unit;

  logic clk;
  logic reset;
  hazard_unit_if hif ();

  hazard_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall, clrE, stall_md;
    logic [1:0]  frsD, frtD, frsE, frtE;
    logic        frtM, busy;
    logic [15:0] sc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] sc_model = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input logic st, input logic cl, input logic sm,
                            input logic [1:0] rsd, input logic [1:0] rtd,
                            input logic [1:0] rse, input logic [1:0] rte,
                            input logic rtm, input logic bsy);
    exp_t e;
    e = '{stall: st, clrE: cl, stall_md: sm, frsD: rsd, frtD: rtd, frsE: rse,
          frtE: rte, frtM: rtm, busy: bsy, sc: sc_model};
    sb.push_back(e);
  endtask

  // Compare at the falling edge, then advance past the next rising edge
  task automatic cyc();
    exp_t e;
    e = '0;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("stall",        hif.stall,        e.stall);
      chk("clrE",         hif.clrE,         e.clrE);
      chk("stall_md",     hif.stall_md,     e.stall_md);
      chk("fwd_rs_D",     hif.fwd_rs_D,     e.frsD);
      chk("fwd_rt_D",     hif.fwd_rt_D,     e.frtD);
      chk("fwd_rs_E",     hif.fwd_rs_E,     e.frsE);
      chk("fwd_rt_E",     hif.fwd_rt_E,     e.frtE);
      chk("fwd_rt_M",     hif.fwd_rt_M,     e.frtM);
      chk("md_busy",      hif.md_busy,      e.busy);
      chk("stall_cycles", hif.stall_cycles, e.sc);
    end
    if (reset) sc_model = 16'd0;
    else if (e.stall && sc_model != 16'hFFFF) sc_model = sc_model + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    hif.A1_D = 0; hif.A2_D = 0;
    hif.Tuse_rs0 = 0; hif.Tuse_rs1 = 0;
    hif.Tuse_rt0 = 0; hif.Tuse_rt1 = 0; hif.Tuse_rt2 = 0;
    hif.md_use_D = 0;
    hif.A1_E = 0; hif.A2_E = 0; hif.A3_E = 0; hif.res_E = 0;
    hif.A2_M = 0; hif.A3_M = 0; hif.res_M = 0;
    hif.A3_W = 0; hif.res_W = 0;
    hif.md_start_E = 0; hif.md_div_E = 0;
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    // Reset state: everything zero
    sc_model = 16'd0;
    expect_out(0,0,0, 0,0,0,0, 0,0);
    cyc();
    reset = 1'b0;

    // lw $3 in E, beq uses $3 in D
    hif.res_E = 3'd2; hif.A3_E = 5'd3; hif.A1_D = 5'd3; hif.Tuse_rs0 = 1;
    expect_out(1,1,0, 0,0,0,0, 0,0); cyc();
    hif.res_E = 0; hif.A3_E = 0; hif.res_M = 3'd2; hif.A3_M = 5'd3;
    expect_out(1,1,0, 0,0,0,0, 0,0); cyc();
    hif.res_M = 0; hif.A3_M = 0; hif.res_W = 3'd2; hif.A3_W = 5'd3;
    expect_out(0,0,0, 2,0,0,0, 0,0); cyc();

    // rt with Tuse=1 vs lw in E (stall) and in M (no stall)
    clr_in();
    hif.res_E = 3'd2; hif.A3_E = 5'd9; hif.A2_D = 5'd9; hif.Tuse_rt1 = 1;
    expect_out(1,1,0, 0,0,0,0, 0,0); cyc();
    hif.res_E = 0; hif.A3_E = 0; hif.res_M = 3'd2; hif.A3_M = 5'd9;
    expect_out(0,0,0, 0,0,0,0, 0,0); cyc();
    // ALU in E: rt needed in M waits for nothing, rs needed in D stalls
    clr_in();
    hif.res_E = 3'd1; hif.A3_E = 5'd4; hif.A2_D = 5'd4; hif.Tuse_rt2 = 1;
    expect_out(0,0,0, 0,0,0,0, 0,0); cyc();
    hif.A1_D = 5'd4; hif.Tuse_rs0 = 1;
    expect_out(1,1,0, 0,0,0,0, 0,0); cyc();

    // jal in E, jr $31 in D
    clr_in();
    hif.res_E = 3'd3; hif.A3_E = 5'd31; hif.A1_D = 5'd31; hif.Tuse_rs0 = 1;
    expect_out(0,0,0, 3,0,0,0, 0,0); cyc();
    hif.A1_D = 5'd0;
    expect_out(0,0,0, 0,0,0,0, 0,0); cyc();

    // E-stage operand forwarding: M beats W, NW in M falls back to W
    clr_in();
    hif.res_M = 3'd1; hif.A3_M = 5'd5; hif.res_W = 3'd2; hif.A3_W = 5'd5; hif.A2_E = 5'd5;
    expect_out(0,0,0, 0,0,0,1, 0,0); cyc();
    hif.res_M = 3'd0;
    expect_out(0,0,0, 0,0,0,2, 0,0); cyc();
    hif.A1_E = 5'd5; hif.A2_M = 5'd5;
    expect_out(0,0,0, 0,0,2,2, 1,0); cyc();
    hif.A3_W = 5'd0; hif.A1_E = 5'd0; hif.A2_E = 5'd0; hif.A2_M = 5'd0;
    expect_out(0,0,0, 0,0,0,0, 0,0); cyc();

    // mult with md_use_D held: six md stalls
    clr_in();
    hif.md_use_D = 1; hif.md_start_E = 1; hif.md_div_E = 0;
    expect_out(1,0,1, 0,0,0,0, 0,1); cyc();
    hif.md_start_E = 0;
    for (int i = 1; i < 6; i++) begin
      expect_out(1,0,1, 0,0,0,0, 0,1); cyc();
    end
    expect_out(0,0,0, 0,0,0,0, 0,0); cyc();

    // div variant: eleven md stalls
    hif.md_start_E = 1; hif.md_div_E = 1;
    expect_out(1,0,1, 0,0,0,0, 0,1); cyc();
    hif.md_start_E = 0;
    for (int i = 1; i < 11; i++) begin
      expect_out(1,0,1, 0,0,0,0, 0,1); cyc();
    end
    expect_out(0,0,0, 0,0,0,0, 0,0); cyc();

    // Data hazard takes priority over md busy
    hif.md_start_E = 1; hif.md_div_E = 0;
    hif.res_E = 3'd2; hif.A3_E = 5'd6; hif.A1_D = 5'd6; hif.Tuse_rs1 = 1;
    expect_out(1,1,0, 0,0,0,0, 0,1); cyc();
    clr_in();
    for (int i = 1; i < 5; i++) begin
      expect_out(0,0,0, 0,0,0,0, 0,1); cyc();
    end
    // Restart while the count is at 1: busy continues without a gap
    hif.md_start_E = 1;
    expect_out(0,0,0, 0,0,0,0, 0,1); cyc();
    hif.md_start_E = 0;
    for (int i = 0; i < 5; i++) begin
      expect_out(0,0,0, 0,0,0,0, 0,1); cyc();
    end
    expect_out(0,0,0, 0,0,0,0, 0,0); cyc();

    // Reset three cycles into a divide aborts the count and clears stall_cycles
    hif.md_use_D = 1; hif.md_start_E = 1; hif.md_div_E = 1;
    expect_out(1,0,1, 0,0,0,0, 0,1); cyc();
    hif.md_start_E = 0;
    expect_out(1,0,1, 0,0,0,0, 0,1); cyc();
    expect_out(1,0,1, 0,0,0,0, 0,1); cyc();
    clr_in();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sc_model = 16'd0;
    hif.md_use_D = 1;
    expect_out(0,0,0, 0,0,0,0, 0,0); cyc();

    // Saturation of stall_cycles
    clr_in();
    hif.res_E = 3'd2; hif.A3_E = 5'd3; hif.A1_D = 5'd3; hif.Tuse_rs0 = 1;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      if (sc_model != 16'hFFFF) sc_model = sc_model + 16'd1;
    end
    #1;
    expect_out(1,1,0, 0,0,0,0, 0,0); cyc();
    clr_in();
    expect_out(0,0,0, 0,0,0,0, 0,0); cyc();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
